// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view; the stream source / memory side takes the master view.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into 32-bit
// instruction words and writes them to consecutive word addresses from 0.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR0  = 3'd1;
  localparam logic [2:0] HDR1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic [2:0]  state, state_nx;
  logic [15:0] n;
  logic [15:0] widx;
  logic [1:0]  k;
  logic [23:0] asm_word;
  logic        xfer;
  logic [15:0] hdr;

  assign xfer = bus.in_valid && bus.in_ready;
  assign hdr  = {bus.in_data, n[7:0]};

  assign bus.in_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign bus.we       = (state == WRITE);
  assign busy         = bus.in_ready || (state == WRITE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);

  always_comb begin
    // NOTE: default assignment first so every path drives state_nx; a missing path would infer a latch.
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = HDR0;
      HDR0:            if (xfer) state_nx = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr == 16'd0)                   state_nx = DONE;
          else if ({1'b0, hdr} > DEPTH_LIM)   state_nx = ERR;
          else                                state_nx = DATA;
        end
      end
      DATA:            if (xfer && k == 2'd3) state_nx = WRITE;
      WRITE:           state_nx = (widx == n - 16'd1) ? DONE : DATA;
      default:         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      widx      <= '0;
      k         <= '0;
      asm_word  <= '0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state <= state_nx;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            n    <= '0;
            widx <= '0;
            k    <= '0;
          end
        end
        HDR0: if (xfer) n[7:0] <= bus.in_data;
        HDR1: begin
          if (xfer) begin
            n[15:8] <= bus.in_data;
            k       <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            k <= k + 2'd1;
            case (k)
              2'd0:    asm_word[7:0]   <= bus.in_data;
              2'd1:    asm_word[15:8]  <= bus.in_data;
              2'd2:    asm_word[23:16] <= bus.in_data;
              default: begin
                // Word complete: present it on the write port for the WRITE cycle.
                bus.wdata <= {bus.in_data, asm_word};
                bus.waddr <= {14'd0, widx, 2'b00};
              end
            endcase
          end
        end
        WRITE: begin
          widx <= widx + 16'd1;
          k    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction-memory words available to load.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock domain, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 SHALL have port in_data  input  8  stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 SHALL have port we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port waddr  output  32  byte address of the word being written, always word-aligned (bits [1:0] = 0).
REQ-010 SHALL have port wdata  output  32  instruction word being written.
REQ-011 SHALL have port busy  output  1  session in progress; the CPU is held in reset while busy is 1.
REQ-012 SHALL have port done  output  1  sticky flag: last session completed successfully.
REQ-013 SHALL have port err  output  1  sticky flag: last session rejected.

Function
REQ-014 SHALL implement states IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-015 Stream format SHALL be: 16-bit word count N (low byte first), then N words of 4 bytes each, least-significant byte first.
REQ-016 IDLE, DONE, ERR: in_ready=0; start=1 -> HDR0, clearing done, err, and the word index to 0.
REQ-017 HDR0: in_ready=1; on transfer, capture N[7:0] -> HDR1.
REQ-018 HDR1: in_ready=1; on transfer, capture N[15:8]; N==0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA with byte index 0.
REQ-019 DATA: in_ready=1; on transfer, place the byte at bits [8*k+7:8*k] (k = byte index), increment k; on the 4th byte (k==3) -> WRITE.
REQ-020 WRITE: in_ready=0; we=1 for exactly this cycle; waddr = word index * 4; wdata = the assembled word; increment word index; last word (index == N-1) -> DONE, otherwise -> DATA with k=0.
REQ-021 Latency SHALL be exactly one cycle from acceptance of a word's 4th byte to its we pulse; peak throughput 4 bytes per 5 cycles.
REQ-022 Cycles with in_valid=0 in HDR0, HDR1, or DATA SHALL change no state (bubbles tolerated, arbitrary length).
REQ-023 busy SHALL be 1 in HDR0, HDR1, DATA, and WRITE, and 0 otherwise.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; both are held until the next accepted start or reset.
REQ-026 ERR SHALL produce no we pulse for the rejected session; words written by earlier sessions are not altered.
REQ-027 waddr and wdata SHALL hold their last values when we=0; consumers sample them only when we=1.
REQ-028 The word index SHALL not exceed DEPTH-1; no write address >= 4*DEPTH is ever issued.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE and drive in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, and clear N, k, and the word index.
REQ-030 Reset asserted mid-session SHALL abandon the session without a further we pulse; a partially assembled word is discarded.
REQ-031 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-032 start, then bytes 02 00 93 02 10 11 23 28 50 0c -> we at waddr 0x0 with wdata 0x11100293, then we at waddr 0x4 with wdata 0x0c502823; done=1, busy=0.
REQ-033 start, then bytes 00 00 -> DONE after the 2nd byte, no we pulse, done=1.
REQ-034 DEPTH=64, start, then bytes 41 00 -> err=1, no we pulse, in_ready=0; a later start clears err.
REQ-035 Same stream as REQ-032 with random in_valid gaps of 0-5 cycles -> identical we/waddr/wdata sequence, each we exactly one cycle after the word's 4th byte.
REQ-036 rst_n pulsed low after the 2nd payload byte -> all outputs 0 immediately with no we pulse; a fresh start with the REQ-032 stream loads correctly.
REQ-037 start pulsed during DATA -> ignored, load completes normally; start pulsed in DONE -> new session begins in HDR0 with done=0.
